// File: rtl/mem_access_guard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_guard_pkg
// Description : Access codes, CP0 exception codes and width/direction helpers
//               for the memory-stage address guard.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_guard_pkg;

    localparam logic [3:0] LW  = 4'd0;
    localparam logic [3:0] SW  = 4'd1;
    localparam logic [3:0] LH  = 4'd2;
    localparam logic [3:0] LB  = 4'd3;
    localparam logic [3:0] LHU = 4'd4;
    localparam logic [3:0] LBU = 4'd5;
    localparam logic [3:0] SH  = 4'd6;
    localparam logic [3:0] SB  = 4'd7;
    localparam logic [3:0] NO  = 4'd8;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    function automatic logic is_word(input logic [3:0] code);
        return (code == LW) || (code == SW);
    endfunction

    function automatic logic is_half(input logic [3:0] code);
        return (code == LH) || (code == LHU) || (code == SH);
    endfunction

    function automatic logic is_byte(input logic [3:0] code);
        return (code == LB) || (code == LBU) || (code == SB);
    endfunction

    function automatic logic is_store(input logic [3:0] code);
        return (code == SW) || (code == SH) || (code == SB);
    endfunction

    // Codes 8..15 are "no access" and fall through every class.
    function automatic logic is_load(input logic [3:0] code);
        return (code == LW) || (code == LH) || (code == LB) ||
               (code == LHU) || (code == LBU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_guard_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_guard_if
// Description : M-stage request, classification and CP0 exception-record
//               signals of the memory-stage address guard.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_guard_if #(
    parameter int NUM_DEV = 6,
    parameter int CNT_W   = 16
);
    logic                req_valid;
    logic                flush;
    logic [31:0]         addr;
    logic [3:0]          code;
    logic [31:0]         pc;
    logic [1:0]          addr_exc;
    logic [NUM_DEV-1:0]  dev_hit;
    logic                exc_valid;
    logic [4:0]          exc_code;
    logic [31:0]         bad_vaddr;
    logic [31:0]         exc_pc;
    logic                exc_ack;
    logic                exc_overflow;
    logic [CNT_W-1:0]    exc_count;
    logic                cnt_clr;

    // Pipeline and CP0 side.
    modport master (
        output req_valid, flush, addr, code, pc, exc_ack, cnt_clr,
        input  addr_exc, dev_hit, exc_valid, exc_code, bad_vaddr, exc_pc,
               exc_overflow, exc_count
    );

    // Guard side.
    modport slave (
        input  req_valid, flush, addr, code, pc, exc_ack, cnt_clr,
        output addr_exc, dev_hit, exc_valid, exc_code, bad_vaddr, exc_pc,
               exc_overflow, exc_count
    );
endinterface
`default_nettype wire

// File: rtl/mem_region_match.sv
`default_nettype none
// ============================================================================
// Module      : mem_region_match
// Description : Inclusive unsigned address-window compare for one region.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_region_match (
    input  wire logic [31:0] addr,
    input  wire logic [31:0] base,
    input  wire logic [31:0] last,
    output logic             hit
);
    assign hit = (addr >= base) && (addr <= last);
endmodule
`default_nettype wire

// File: rtl/mem_access_guard.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_guard
// Description : Classifies M-stage loads/stores against data memory and device
//               regions, captures the first fault for CP0, counts faults.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_guard
    import mem_guard_pkg::*;
#(
    parameter int                      NUM_DEV       = 6,
    parameter logic [31:0]             DM_LAST       = 32'h0000_2FFF,
    parameter logic [32*NUM_DEV-1:0]   DEV_BASE      = {32'h7F40, 32'h7F38, 32'h7F34,
                                                        32'h7F2C, 32'h7F10, 32'h7F00},
    parameter logic [32*NUM_DEV-1:0]   DEV_LAST      = {32'h7F43, 32'h7F3F, 32'h7F37,
                                                        32'h7F33, 32'h7F2B, 32'h7F0B},
    parameter logic [NUM_DEV-1:0]      DEV_WORD_ONLY = 6'b000001,
    parameter int                      RO_NUM        = 2,
    parameter logic [32*RO_NUM-1:0]    RO_ADDR       = {32'h7F18, 32'h7F08},
    parameter int                      CNT_W         = 16
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    mem_access_guard_if.slave bus
);

    logic [NUM_DEV-1:0] w_raw_hit;
    logic [NUM_DEV-1:0] w_dev_hit;
    logic [RO_NUM-1:0]  w_ro_hit;
    logic               w_store;
    logic               w_active;
    logic               w_in_range;
    logic               w_misalign;
    logic               w_word_only;
    logic               w_fault;
    logic               w_ack;

    logic               r_exc_valid;
    logic [4:0]         r_exc_code;
    logic [31:0]        r_bad_vaddr;
    logic [31:0]        r_exc_pc;
    logic               r_exc_overflow;
    logic [CNT_W-1:0]   r_exc_count;

    for (genvar i = 0; i < NUM_DEV; i++) begin : g_region
        mem_region_match u_match (
            .addr (bus.addr),
            .base (DEV_BASE[32*i +: 32]),
            .last (DEV_LAST[32*i +: 32]),
            .hit  (w_raw_hit[i])
        );
    end

    for (genvar k = 0; k < RO_NUM; k++) begin : g_ro
        assign w_ro_hit[k] = (bus.addr[31:2] == RO_ADDR[32*k+2 +: 30]);
    end

    // Isolate the lowest set bit so overlapping regions report one index.
    assign w_dev_hit = bus.req_valid ? (w_raw_hit & ((~w_raw_hit) + NUM_DEV'(1)))
                                     : '0;

    assign w_store     = is_store(bus.code);
    assign w_active    = bus.req_valid && !bus.flush && (is_load(bus.code) || w_store);
    assign w_in_range  = (bus.addr <= DM_LAST) || (|w_raw_hit);
    assign w_misalign  = (is_word(bus.code) && (bus.addr[1:0] != 2'b00)) ||
                         (is_half(bus.code) && bus.addr[0]);
    assign w_word_only = (is_half(bus.code) || is_byte(bus.code)) &&
                         (|(w_raw_hit & DEV_WORD_ONLY));
    assign w_fault     = w_active && (!w_in_range || w_misalign || w_word_only ||
                                      (w_store && (|w_ro_hit)));
    assign w_ack       = bus.exc_ack && r_exc_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_exc_valid    <= 1'b0;
            r_exc_code     <= 5'd0;
            r_bad_vaddr    <= 32'd0;
            r_exc_pc       <= 32'd0;
            r_exc_overflow <= 1'b0;
            r_exc_count    <= '0;
        end else begin
            if (w_fault) begin
                if (!r_exc_valid || w_ack) begin
                    r_exc_valid <= 1'b1;
                    r_exc_code  <= w_store ? EXC_ADES : EXC_ADEL;
                    r_bad_vaddr <= bus.addr;
                    r_exc_pc    <= bus.pc;
                end else begin
                    r_exc_overflow <= 1'b1;
                end
            end else if (w_ack) begin
                r_exc_valid <= 1'b0;
            end

            // Clear has priority over both the increment and a new overflow.
            if (bus.cnt_clr) begin
                r_exc_count    <= '0;
                r_exc_overflow <= 1'b0;
            end else if (w_fault && (r_exc_count != {CNT_W{1'b1}})) begin
                r_exc_count <= r_exc_count + CNT_W'(1);
            end
        end
    end

    assign bus.addr_exc     = w_fault ? {1'b1, w_store} : 2'b00;
    assign bus.dev_hit      = w_dev_hit;
    assign bus.exc_valid    = r_exc_valid;
    assign bus.exc_code     = r_exc_code;
    assign bus.bad_vaddr    = r_bad_vaddr;
    assign bus.exc_pc       = r_exc_pc;
    assign bus.exc_overflow = r_exc_overflow;
    assign bus.exc_count    = r_exc_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_guard.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_guard
// Description : Directed self-checking bench for mem_access_guard (CNT_W=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_guard;

    localparam int NUM_DEV = 6;
    localparam int CNT_W   = 3;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    mem_access_guard_if #(.NUM_DEV(NUM_DEV), .CNT_W(CNT_W)) bus ();

    mem_access_guard #(.NUM_DEV(NUM_DEV), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one M-stage cycle's inputs and let combinational outputs settle.
    task automatic drive(input logic v, input logic fl, input logic [31:0] a,
                         input logic [3:0] c, input logic [31:0] p,
                         input logic ack, input logic clr);
        bus.req_valid = v;
        bus.flush     = fl;
        bus.addr      = a;
        bus.code      = c;
        bus.pc        = p;
        bus.exc_ack   = ack;
        bus.cnt_clr   = clr;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 4'd8, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 4'd8, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_valid", 32'(bus.exc_valid), 32'd0);
        check_value("rst_code", 32'(bus.exc_code), 32'd0);
        check_value("rst_vaddr", bus.bad_vaddr, 32'd0);
        check_value("rst_pc", bus.exc_pc, 32'd0);
        check_value("rst_ovf", 32'(bus.exc_overflow), 32'd0);
        check_value("rst_cnt", 32'(bus.exc_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // DM upper boundary
        drive(1'b1, 1'b0, 32'h2FFC, 4'd1, 32'h0FC, 1'b0, 1'b0);
        check_value("sw_2ffc_exc", 32'(bus.addr_exc), 32'd0);
        check_value("sw_2ffc_hit", 32'(bus.dev_hit), 32'd0);
        step();
        drive(1'b1, 1'b0, 32'h3000, 4'd0, 32'h0FC, 1'b0, 1'b0);
        check_value("lw_3000_exc", 32'(bus.addr_exc), 32'b10);
        drive(1'b1, 1'b0, 32'h2FFE, 4'd0, 32'h100, 1'b0, 1'b0);
        check_value("lw_2ffe_exc", 32'(bus.addr_exc), 32'b10);
        step();
        check_value("rec1_valid", 32'(bus.exc_valid), 32'd1);
        check_value("rec1_code", 32'(bus.exc_code), 32'd4);
        check_value("rec1_vaddr", bus.bad_vaddr, 32'h2FFE);
        check_value("rec1_pc", bus.exc_pc, 32'h100);
        check_value("rec1_cnt", 32'(bus.exc_count), 32'd1);

        // Write-protected word in a word-only region, acked in the same cycle
        drive(1'b1, 1'b0, 32'h7F08, 4'd6, 32'h104, 1'b1, 1'b0);
        check_value("sh_7f08_exc", 32'(bus.addr_exc), 32'b11);
        check_value("sh_7f08_hit", 32'(bus.dev_hit), 32'b000001);
        step();
        check_value("rec2_valid", 32'(bus.exc_valid), 32'd1);
        check_value("rec2_code", 32'(bus.exc_code), 32'd5);
        check_value("rec2_vaddr", bus.bad_vaddr, 32'h7F08);
        check_value("rec2_ovf", 32'(bus.exc_overflow), 32'd0);
        check_value("rec2_cnt", 32'(bus.exc_count), 32'd2);
        drive(1'b0, 1'b0, 32'h0, 4'd8, 32'h0, 1'b1, 1'b0);
        step();
        check_value("ack_valid", 32'(bus.exc_valid), 32'd0);
        check_value("ack_hold", bus.bad_vaddr, 32'h7F08);
        drive(1'b0, 1'b0, 32'h0, 4'd8, 32'h0, 1'b1, 1'b0);
        step();
        check_value("ack_idle", 32'(bus.exc_valid), 32'd0);

        // Device region hits
        drive(1'b1, 1'b0, 32'h7F04, 4'd1, 32'h108, 1'b0, 1'b0);
        check_value("sw_7f04_exc", 32'(bus.addr_exc), 32'd0);
        check_value("sw_7f04_hit", 32'(bus.dev_hit), 32'b000001);
        drive(1'b1, 1'b0, 32'h7F41, 4'd5, 32'h108, 1'b0, 1'b0);
        check_value("lbu_7f41_exc", 32'(bus.addr_exc), 32'd0);
        check_value("lbu_7f41_hit", 32'(bus.dev_hit), 32'b100000);
        drive(1'b0, 1'b0, 32'h7F41, 4'd5, 32'h108, 1'b0, 1'b0);
        check_value("hit_novalid", 32'(bus.dev_hit), 32'd0);
        drive(1'b1, 1'b0, 32'h3001, 4'd8, 32'h108, 1'b0, 1'b0);
        check_value("none_exc", 32'(bus.addr_exc), 32'd0);
        drive(1'b1, 1'b0, 32'h3001, 4'd12, 32'h108, 1'b0, 1'b0);
        check_value("code12_exc", 32'(bus.addr_exc), 32'd0);
        drive(1'b1, 1'b0, 32'h7F0C, 4'd3, 32'h10C, 1'b0, 1'b1);
        check_value("lb_7f0c_exc", 32'(bus.addr_exc), 32'b10);
        check_value("lb_7f0c_hit", 32'(bus.dev_hit), 32'd0);
        step();
        check_value("clr_cnt", 32'(bus.exc_count), 32'd0);

        // Two consecutive faults without ack: first wins
        drive(1'b0, 1'b0, 32'h0, 4'd8, 32'h0, 1'b1, 1'b1);
        step();
        drive(1'b1, 1'b0, 32'h7F0C, 4'd3, 32'h300, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h3000, 4'd0, 32'h304, 1'b0, 1'b0);
        step();
        check_value("ovf_vaddr", bus.bad_vaddr, 32'h7F0C);
        check_value("ovf_pc", bus.exc_pc, 32'h300);
        check_value("ovf_flag", 32'(bus.exc_overflow), 32'd1);
        check_value("ovf_cnt", 32'(bus.exc_count), 32'd2);

        // Ack plus new fault: new record, no overflow
        drive(1'b0, 1'b0, 32'h0, 4'd8, 32'h0, 1'b0, 1'b1);
        step();
        check_value("clr_ovf", 32'(bus.exc_overflow), 32'd0);
        check_value("clr_keep_valid", 32'(bus.exc_valid), 32'd1);
        drive(1'b1, 1'b0, 32'h7F18, 4'd7, 32'h308, 1'b1, 1'b0);
        check_value("sb_7f18_exc", 32'(bus.addr_exc), 32'b11);
        check_value("sb_7f18_hit", 32'(bus.dev_hit), 32'b000010);
        step();
        check_value("ackf_vaddr", bus.bad_vaddr, 32'h7F18);
        check_value("ackf_valid", 32'(bus.exc_valid), 32'd1);
        check_value("ackf_ovf", 32'(bus.exc_overflow), 32'd0);
        check_value("ackf_cnt", 32'(bus.exc_count), 32'd1);

        // Flushed fault is invisible
        drive(1'b1, 1'b1, 32'h2FFE, 4'd0, 32'h30C, 1'b0, 1'b0);
        check_value("flush_exc", 32'(bus.addr_exc), 32'd0);
        step();
        check_value("flush_cnt", 32'(bus.exc_count), 32'd1);
        check_value("flush_vaddr", bus.bad_vaddr, 32'h7F18);
        check_value("flush_ovf", 32'(bus.exc_overflow), 32'd0);

        // Saturation at 7 for CNT_W=3
        drive(1'b0, 1'b0, 32'h0, 4'd8, 32'h0, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 32'h2FFF, 4'd0, 32'h400, 1'b0, 1'b0);
            step();
        end
        check_value("sat8_cnt", 32'(bus.exc_count), 32'd7);
        drive(1'b1, 1'b0, 32'h2FFF, 4'd0, 32'h404, 1'b0, 1'b0);
        step();
        check_value("sat9_cnt", 32'(bus.exc_count), 32'd7);
        drive(1'b1, 1'b0, 32'h2FFF, 4'd0, 32'h408, 1'b0, 1'b1);
        step();
        check_value("clr_win_cnt", 32'(bus.exc_count), 32'd0);

        // Asynchronous reset between clock edges
        check_value("pre_rst_valid", 32'(bus.exc_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_value("arst_valid", 32'(bus.exc_valid), 32'd0);
        check_value("arst_code", 32'(bus.exc_code), 32'd0);
        check_value("arst_vaddr", bus.bad_vaddr, 32'd0);
        check_value("arst_pc", bus.exc_pc, 32'd0);
        check_value("arst_ovf", 32'(bus.exc_overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
